sequence_player: RTL and testbench

- Drives the colour sequence to the game LEDs.
- On `start`, plays segment entries 0..play_round as timed one-hot LED flashes, each followed by a dark gap, then pulses `done`.
- Sits between the sequence generator (owner of `segment`) and the LED outputs.
- It is the producer counterpart of the player-input checker, which consumes the same `segment` array and round index.

---
 rtl/sequence_player.sv | 156 +++++++++++++++
 tb/tb_sequence_player.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/sequence_player.sv
// sequence_player: replays the latched colour sequence as timed one-hot LED
// flashes (ON_CYCLES lit, OFF_CYCLES dark per step), then pulses done.
// All outputs are registered; they are computed from the next-state values so
// that the LEDs show step 0 in the very cycle after start is accepted.
module sequence_player #(
  parameter int ON_CYCLES  = 4,
  parameter int OFF_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic [31:0][2:0] segment,
  input  logic [4:0]      play_round,
  output logic [3:0]      led,
  output logic            busy,
  output logic            done,
  output logic [4:0]      step_idx,
  output logic            bad_code
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ON,
    S_OFF,
    S_DONE
  } state_t;

  // Timers count down to zero, so they are loaded with length-1.
  localparam logic [15:0] ON_LOAD  = 16'(ON_CYCLES - 1);
  localparam logic [15:0] OFF_LOAD = 16'(OFF_CYCLES - 1);

  state_t            r_state, w_state_nxt;
  logic [15:0]       r_timer, w_timer_nxt;
  logic [4:0]        r_step, w_step_nxt;
  logic [4:0]        r_round, w_round_nxt;
  logic [31:0][2:0]  r_seg, w_seg_nxt;
  logic [3:0]        r_led, w_led_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;
  logic              r_bad, w_bad_nxt;
  logic [2:0]        w_code;
  logic              w_accept;

  // Next-state logic for the playback FSM, timer, step index and latches.
  always_comb begin
    // NOTE: every signal gets a hold/default value first so that no branch
    // leaves it unassigned; otherwise synthesis infers a latch.
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_step_nxt  = r_step;
    w_round_nxt = r_round;
    w_seg_nxt   = r_seg;
    w_accept    = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        // abort beats start when both arrive in the same idle cycle.
        if (start && !abort) begin
          w_accept    = 1'b1;
          w_seg_nxt   = segment;
          w_round_nxt = play_round;
          w_step_nxt  = 5'd0;
          w_timer_nxt = ON_LOAD;
          w_state_nxt = S_ON;
        end
      end
      S_ON: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if (r_timer == 16'd0) begin
          w_timer_nxt = OFF_LOAD;
          w_state_nxt = S_OFF;
        end else begin
          w_timer_nxt = r_timer - 16'd1;
        end
      end
      S_OFF: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if (r_timer == 16'd0) begin
          // Comparing against the latched round before incrementing keeps
          // step_idx from ever wrapping past 31.
          if (r_step == r_round) begin
            w_state_nxt = S_DONE;
          end else begin
            w_step_nxt  = r_step + 5'd1;
            w_timer_nxt = ON_LOAD;
            w_state_nxt = S_ON;
          end
        end else begin
          w_timer_nxt = r_timer - 16'd1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Output decode from next-state values, so outputs are registered yet
  // aligned with the state they describe.
  always_comb begin
    w_code     = w_seg_nxt[w_step_nxt];
    w_led_nxt  = 4'b0000;
    w_busy_nxt = (w_state_nxt == S_ON) || (w_state_nxt == S_OFF);
    w_done_nxt = (w_state_nxt == S_DONE);
    w_bad_nxt  = w_accept ? 1'b0 : r_bad;
    if (w_state_nxt == S_ON) begin
      if (w_code[2]) begin
        w_bad_nxt = 1'b1;
      end else begin
        w_led_nxt = 4'b0001 << w_code[1:0];
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the latched sequence is reset along with the control state so
      // nothing stale from a previous game is visible after reset.
      r_state <= S_IDLE;
      r_timer <= '0;
      r_step  <= '0;
      r_round <= '0;
      r_seg   <= '0;
      r_led   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_bad   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
      r_step  <= w_step_nxt;
      r_round <= w_round_nxt;
      r_seg   <= w_seg_nxt;
      r_led   <= w_led_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_bad   <= w_bad_nxt;
    end
  end

  assign led      = r_led;
  assign busy     = r_busy;
  assign done     = r_done;
  assign step_idx = r_step;
  assign bad_code = r_bad;

endmodule

// File: tb/tb_sequence_player.sv
// tb_sequence_player: table-driven playback vectors, a per-cycle reference
// model computed from step/phase arithmetic, random sequences and hand-written
// corner sequences (reset, ignored start, abort).
module tb_sequence_player;

  localparam int ON  = 4;
  localparam int OFF = 2;
  localparam int P   = ON + OFF;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             abort;
  logic [31:0][2:0] segment;
  logic [4:0]       play_round;
  logic [3:0]       led;
  logic             busy;
  logic             done;
  logic [4:0]       step_idx;
  logic             bad_code;

  int n_checks = 0;
  int n_errors = 0;

  sequence_player #(.ON_CYCLES(ON), .OFF_CYCLES(OFF)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .segment   (segment),
    .play_round(play_round),
    .led       (led),
    .busy      (busy),
    .done      (done),
    .step_idx  (step_idx),
    .bad_code  (bad_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0][2:0] seg;
    logic [4:0]       round;
    int               cycles;
    logic             bad;
    logic [4:0]       last;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one clock; afterwards we sit 1 time unit past the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected {led, busy, done, step_idx, bad_code} for cycle k after the start
  // edge: each step occupies P cycles, lit for the first ON of them.
  function automatic logic [11:0] model_out(input logic [31:0][2:0] seg,
                                            input logic [4:0] round, input int k);
    int         n;
    int         s;
    int         ph;
    logic [3:0] e_led;
    logic       e_busy;
    logic       e_done;
    logic [4:0] e_step;
    logic       e_bad;
    n      = (int'(round) + 1) * P;
    e_led  = 4'b0000;
    e_busy = (k < n);
    e_done = (k == n);
    if (k >= n) begin
      s = int'(round);
    end else begin
      s  = k / P;
      ph = k % P;
      if (ph < ON && seg[s] <= 3'd3) e_led = 4'b0001 << seg[s];
    end
    e_step = 5'(s);
    e_bad  = 1'b0;
    for (int i = 0; i <= s; i++) if (seg[i] > 3'd3) e_bad = 1'b1;
    return {e_led, e_busy, e_done, e_step, e_bad};
  endfunction

  // Start a playback and compare every cycle through one idle cycle past done.
  // If disturb_k >= 0, start is re-pulsed at that cycle with new inputs.
  task automatic play_and_check(input string name, input logic [31:0][2:0] seg,
                                input logic [4:0] round, input int disturb_k);
    int n;
    n          = (int'(round) + 1) * P;
    segment    = seg;
    play_round = round;
    start      = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k <= n + 1; k++) begin
      check(name, {led, busy, done, step_idx, bad_code}, model_out(seg, round, k));
      if (k == disturb_k) begin
        start      = 1'b1;
        segment    = {$urandom, $urandom, $urandom};
        play_round = 5'($urandom);
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
  endtask

  logic [31:0][2:0] seg_v;
  logic [31:0][2:0] seg_full;
  int               k;

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    segment    = '0;
    play_round = '0;

    // Vector table: whole-playback results.
    for (int i = 0; i < 32; i++) seg_full[i] = 3'(i % 4);
    seg_v = '0; seg_v[0] = 3'd1; seg_v[1] = 3'd3; seg_v[2] = 3'd0;
    vecs[0] = '{seg: seg_v, round: 5'd2, cycles: 18, bad: 1'b0, last: 5'd2};
    seg_v = '0; seg_v[0] = 3'd2;
    vecs[1] = '{seg: seg_v, round: 5'd0, cycles: 6, bad: 1'b0, last: 5'd0};
    vecs[2] = '{seg: seg_full, round: 5'd31, cycles: 192, bad: 1'b0, last: 5'd31};
    seg_v = '0; seg_v[0] = 3'd2; seg_v[1] = 3'd5;
    vecs[3] = '{seg: seg_v, round: 5'd1, cycles: 12, bad: 1'b1, last: 5'd1};
    seg_v = '0; seg_v[0] = 3'd1; seg_v[1] = 3'd3; seg_v[2] = 3'd0;
    vecs[4] = '{seg: seg_v, round: 5'd2, cycles: 18, bad: 1'b0, last: 5'd2};

    #12;
    check("reset_outputs", {led, busy, done, step_idx, bad_code}, 12'h000);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int v = 0; v < 5; v++) begin
      segment    = vecs[v].seg;
      play_round = vecs[v].round;
      start      = 1'b1;
      tick();
      start = 1'b0;
      check("vec_bad_at_start", 32'(bad_code), 32'(vecs[v].seg[0] > 3'd3));
      k = 0;
      while (done !== 1'b1 && k < 400) begin
        tick();
        k++;
      end
      check("vec_done_cycle", k, vecs[v].cycles);
      check("vec_busy_at_done", 32'(busy), 32'd0);
      check("vec_bad_at_done", 32'(bad_code), 32'(vecs[v].bad));
      check("vec_last_step", 32'(step_idx), 32'(vecs[v].last));
      tick();
      check("vec_done_pulse_len", 32'(done), 32'd0);
    end

    // Per-cycle traces: basic, full length, invalid code.
    play_and_check("trace_basic", vecs[0].seg, vecs[0].round, -1);
    play_and_check("trace_full", seg_full, 5'd31, -1);
    play_and_check("trace_invalid", vecs[3].seg, vecs[3].round, -1);

    // Start re-pulsed at cycle 7 with changed inputs: must be ignored.
    play_and_check("trace_ignored_start", vecs[0].seg, vecs[0].round, 7);

    // Random sequences (codes 0..7, rounds 0..7).
    for (int r = 0; r < 8; r++) begin
      seg_v = {$urandom, $urandom, $urandom};
      play_and_check("trace_random", seg_v, 5'($urandom_range(7, 0)), -1);
    end

    // Abort at cycle 5 of a round-3 playback.
    seg_v = '0; seg_v[0] = 3'd1; seg_v[1] = 3'd2; seg_v[2] = 3'd3; seg_v[3] = 3'd0;
    segment    = seg_v;
    play_round = 5'd3;
    start      = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_idle", {led, busy, done}, 6'b0);
    k = 0;
    for (int i = 0; i < 30; i++) begin
      if (done === 1'b1 || busy === 1'b1) k++;
      tick();
    end
    check("abort_no_done", k, 0);
    play_and_check("trace_after_abort", seg_v, 5'd3, -1);

    // Abort and start in the same idle cycle: stay idle.
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("abort_beats_start", {led, busy, done}, 6'b0);
    tick();
    check("abort_beats_start_2", 32'(busy), 32'd0);

    // Asynchronous reset in the middle of a lit code-2 step.
    seg_v = '0; seg_v[0] = 3'd2;
    segment    = seg_v;
    play_round = 5'd3;
    start      = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("pre_reset_led", 32'(led), 32'h4);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", {led, busy, done, step_idx, bad_code}, 12'h000);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_reset_idle", {led, busy, done}, 6'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
